fx_channel_sched: RTL and testbench

- Stereo sample scheduler that shares one single-channel effect datapath (e.g. the distortion clipper) between the left and right audio channels.
- Captures a stereo pair on each codec audio_ready strobe.
- Feeds left then right through the effect using a start/done handshake, with timeout protection, then presents both processed samples together with a one-cycle valid pulse.
- Sits between the audio codec interface and the effect datapath; handles effect bypass and error flags.

---
 rtl/fx_channel_sched.sv | 174 +++++++++++++++++
 tb/tb_fx_channel_sched.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/fx_channel_sched.sv
// Stereo scheduler: captures a left/right pair, runs each sample through one shared
// effect datapath (start/done with timeout fallback) and presents both results together.
module fx_channel_sched #(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255,
  parameter int CNT_W      = 8
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic                  audio_ready,
  input  logic [DATA_WIDTH-1:0] left_in,
  input  logic [DATA_WIDTH-1:0] right_in,
  input  logic                  en,
  output logic [DATA_WIDTH-1:0] fx_x,
  output logic                  fx_start,
  input  logic                  fx_done,
  input  logic [DATA_WIDTH-1:0] fx_y,
  output logic [DATA_WIDTH-1:0] left_out,
  output logic [DATA_WIDTH-1:0] right_out,
  output logic                  out_valid,
  output logic                  busy,
  output logic                  indicator,
  output logic                  overrun,
  output logic                  timeout_err,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEND_L = 3'd1,
    WAIT_L = 3'd2,
    SEND_R = 3'd3,
    WAIT_R = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] lbuf_q, lbuf_d, rbuf_q, rbuf_d;
  logic [DATA_WIDTH-1:0] lres_q, lres_d, rres_q, rres_d;
  logic [DATA_WIDTH-1:0] fx_x_q, fx_x_d, left_out_q, left_out_d, right_out_q, right_out_d;
  logic                  fx_start_q, fx_start_d, out_valid_q, out_valid_d, busy_q, busy_d;
  logic                  ind_q, ind_d, ovr_q, ovr_d, terr_q, terr_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lbuf_d      = lbuf_q;
    rbuf_d      = rbuf_q;
    lres_d      = lres_q;
    rres_d      = rres_q;
    ind_d       = ind_q;
    ovr_d       = ovr_q;
    terr_d      = terr_q;
    fx_x_d      = fx_x_q;
    left_out_d  = left_out_q;
    right_out_d = right_out_q;

    case (state_q)
      IDLE: begin
        if (audio_ready) begin
          lbuf_d = left_in;
          rbuf_d = right_in;
          ind_d  = en;
          if (en) begin
            state_d = SEND_L;
          end else begin
            lres_d  = left_in;
            rres_d  = right_in;
            state_d = DONE;
          end
        end
      end
      SEND_L: begin
        cnt_d   = '0;
        state_d = WAIT_L;
      end
      WAIT_L: begin
        // A done arriving on the last allowed cycle still wins over the timeout.
        if (fx_done) begin
          lres_d  = fx_y;
          state_d = SEND_R;
        end else if (cnt_q == CNT_LAST) begin
          lres_d  = lbuf_q;
          terr_d  = 1'b1;
          state_d = SEND_R;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SEND_R: begin
        cnt_d   = '0;
        state_d = WAIT_R;
      end
      WAIT_R: begin
        if (fx_done) begin
          rres_d  = fx_y;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          rres_d  = rbuf_q;
          terr_d  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (audio_ready && (state_q != IDLE)) ovr_d = 1'b1;

    // Outputs are registered, so they are decoded from the state being entered.
    fx_start_d  = (state_d == SEND_L) || (state_d == SEND_R);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
    if (state_d == SEND_L) fx_x_d = lbuf_d;
    if (state_d == SEND_R) fx_x_d = rbuf_q;
    if (state_d == DONE) begin
      left_out_d  = lres_d;
      right_out_d = rres_d;
    end
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      lbuf_q      <= '0;
      rbuf_q      <= '0;
      lres_q      <= '0;
      rres_q      <= '0;
      ind_q       <= 1'b0;
      ovr_q       <= 1'b0;
      terr_q      <= 1'b0;
      fx_x_q      <= '0;
      fx_start_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      left_out_q  <= '0;
      right_out_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lbuf_q      <= lbuf_d;
      rbuf_q      <= rbuf_d;
      lres_q      <= lres_d;
      rres_q      <= rres_d;
      ind_q       <= ind_d;
      ovr_q       <= ovr_d;
      terr_q      <= terr_d;
      fx_x_q      <= fx_x_d;
      fx_start_q  <= fx_start_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      left_out_q  <= left_out_d;
      right_out_q <= right_out_d;
    end
  end

  assign fx_x        = fx_x_q;
  assign fx_start    = fx_start_q;
  assign left_out    = left_out_q;
  assign right_out   = right_out_q;
  assign out_valid   = out_valid_q;
  assign busy        = busy_q;
  assign indicator   = ind_q;
  assign overrun     = ovr_q;
  assign timeout_err = terr_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_fx_channel_sched.sv
// Bench for fx_channel_sched: directed frames plus random frames against a frame-level
// model (latency, results, sticky flags) and an effect model answering start requests.
module tb_fx_channel_sched;
  localparam int W  = 32;
  localparam int TO = 4;

  logic         CLK = 1'b0;
  logic         rst = 1'b0;
  logic         audio_ready = 1'b0;
  logic [W-1:0] left_in = '0, right_in = '0;
  logic         en = 1'b0;
  logic [W-1:0] fx_x;
  logic         fx_start;
  logic         fx_done = 1'b0;
  logic [W-1:0] fx_y = '0;
  logic [W-1:0] left_out, right_out;
  logic         out_valid, busy, indicator, overrun, timeout_err;
  logic [2:0]   dbg_state;

  fx_channel_sched #(.DATA_WIDTH(W), .TIMEOUT(TO), .CNT_W(3)) dut (
    .CLK(CLK), .rst(rst), .audio_ready(audio_ready), .left_in(left_in), .right_in(right_in),
    .en(en), .fx_x(fx_x), .fx_start(fx_start), .fx_done(fx_done), .fx_y(fx_y),
    .left_out(left_out), .right_out(right_out), .out_valid(out_valid), .busy(busy),
    .indicator(indicator), .overrun(overrun), .timeout_err(timeout_err), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 CLK = ~CLK;
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  int total = 0;
  int bad = 0;
  logic [W-1:0] exp_q[$];
  int  n_starts = 0;
  bit  err_exp = 0;
  bit  ovr_exp = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // effect model: done arrives eff_lat cycles after the start cycle (0 = never)
  int           eff_lat = 1;
  int           eff_cnt = 0;
  bit           eff_pend = 0;
  bit           stray_en = 0;
  logic [W-1:0] eff_x = '0;
  always @(negedge CLK) begin
    fx_done = 1'b0;
    fx_y    = $urandom;
    if (!rst) begin
      eff_pend = 0;
    end else begin
      if (eff_pend) begin
        eff_cnt--;
        if (eff_cnt == 0) begin
          fx_done  = 1'b1;
          fx_y     = eff_x >> 1;
          eff_pend = 0;
        end
      end
      if (stray_en) fx_done = 1'($urandom_range(0, 1));
      if (fx_start && eff_lat > 0) begin
        eff_pend = 1;
        eff_cnt  = eff_lat;
        eff_x    = fx_x;
      end
    end
  end

  // start monitor: each start must present the next expected sample
  always @(negedge CLK) begin
    if (rst && fx_start) begin
      n_starts++;
      if (exp_q.size() == 0) chk("fx_start_unexpected", 1, 0);
      else chk("fx_x", fx_x, exp_q.pop_front());
    end
  end

  function automatic bit chan_ok(input int lat);
    return (lat >= 1) && (lat <= TO);
  endfunction

  // driver + frame-level reference check
  task automatic run_frame(input logic [W-1:0] l, input logic [W-1:0] r, input bit e,
                           input int lat, input int ovr_at, input bit toggle_en);
    logic [W-1:0] exp_l, exp_r;
    int exp_cyc, k, s0, ovr_k;
    bit got;
    exp_l = (e && chan_ok(lat)) ? (l >> 1) : l;
    exp_r = (e && chan_ok(lat)) ? (r >> 1) : r;
    exp_cyc = e ? 1 + 2 * (1 + (chan_ok(lat) ? lat : TO)) : 1;
    if (e && !chan_ok(lat)) err_exp = 1;
    ovr_k = (ovr_at > exp_cyc) ? exp_cyc : ovr_at;
    if (ovr_k > 0) ovr_exp = 1;
    if (e) begin
      exp_q.push_back(l);
      exp_q.push_back(r);
    end
    stray_en = !e;
    @(negedge CLK);
    eff_lat = lat; left_in = l; right_in = r; en = e; audio_ready = 1'b1;
    s0 = n_starts;
    k = 0;
    got = 0;
    while (!got && k < 60) begin
      @(negedge CLK);
      k++;
      got = out_valid;
      audio_ready = (k == ovr_k);
      if (audio_ready) begin
        left_in  = $urandom;
        right_in = $urandom;
      end
      if (toggle_en && k == 2) en = ~e;
    end
    chk("out_valid_seen", got, 1);
    chk("latency", k, exp_cyc);
    chk("left_out", left_out, exp_l);
    chk("right_out", right_out, exp_r);
    chk("indicator", indicator, e);
    chk("timeout_err", timeout_err, err_exp);
    @(negedge CLK);
    audio_ready = 1'b0;
    stray_en = 0;
    chk("overrun", overrun, ovr_exp);
    chk("out_valid_single", out_valid, 0);
    chk("busy_after", busy, 0);
    chk("left_hold", left_out, exp_l);
    chk("n_starts", n_starts - s0, e ? 2 : 0);
    chk("exp_q_empty", exp_q.size(), 0);
  endtask

  initial begin
    int k;
    repeat (2) @(negedge CLK);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_left", left_out, 0);
    chk("rst_fx_start", fx_start, 0);
    rst = 1'b1;

    // bypass, normal, done on final wait cycle, then full timeout
    run_frame(32'h00123456, 32'hFF800000, 0, 1, 0, 0);
    run_frame(32'h00400000, 32'h00200000, 1, 3, 0, 0);
    run_frame(32'h80000001, 32'h7FFFFFFF, 1, TO, 0, 0);
    run_frame(32'hDEADBEEF, 32'h01234567, 1, 0, 0, 0);

    // reset in the middle of WAIT_R
    exp_q.push_back(32'h11110000);
    exp_q.push_back(32'h22220000);
    @(negedge CLK);
    eff_lat = 3; left_in = 32'h11110000; right_in = 32'h22220000; en = 1; audio_ready = 1;
    k = 0;
    do begin
      @(negedge CLK);
      audio_ready = 0;
      k++;
    end while (dbg_state !== 3'd4 && k < 30);
    chk("reached_wait_r", dbg_state, 3'd4);
    rst = 1'b0;
    #1;
    chk("mid_rst_state", dbg_state, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_left", left_out, 0);
    chk("mid_rst_right", right_out, 0);
    chk("mid_rst_fx_x", fx_x, 0);
    chk("mid_rst_flags", {busy, indicator, overrun, timeout_err, fx_start}, 0);
    exp_q.delete();
    err_exp = 0;
    ovr_exp = 0;
    repeat (3) begin
      @(negedge CLK);
      chk("rst_hold_out_valid", out_valid, 0);
    end
    rst = 1'b1;
    run_frame(32'h00400000, 32'h00200000, 1, 1, 0, 0);

    // overrun two cycles after capture, then en dropping during WAIT_L
    run_frame(32'h0000F000, 32'hFFFF0000, 1, 3, 2, 0);
    run_frame(32'h12345678, 32'h87654321, 1, 2, 0, 1);
    run_frame(32'hCAFEF00D, 32'h0BADBEEF, 0, 2, 0, 0);

    // random frames, including late dones and overruns landing in DONE
    for (int i = 0; i < 24; i++) begin
      run_frame($urandom, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, TO + 1),
                ($urandom_range(0, 3) == 0) ? $urandom_range(1, 20) : 0, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
